// File: rtl/alu_add.sv
// ============================================================================
// Module      : alu_add
// Description : Saturating signed adder, out = clamp(acc + arg1) to +/-MAX_VAL,
//               registered with 1-cycle latency. Optional sat_pos/sat_neg
//               status flags are enabled by defining ADD_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_add #(
    parameter int WIDTH   = 11,
    parameter int MAX_VAL = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] arg1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sat_pos,
    output logic             sat_neg
);

    // Bounds in the extended (WIDTH+1) domain, where the sum cannot wrap
    localparam logic signed [WIDTH:0]   c_max_ext = MAX_VAL[WIDTH:0];
    localparam logic signed [WIDTH:0]   c_min_ext = -c_max_ext;
    localparam logic        [WIDTH-1:0] c_max_out = MAX_VAL[WIDTH-1:0];
    localparam logic        [WIDTH-1:0] c_min_out = c_min_ext[WIDTH-1:0];

    function automatic logic signed [WIDTH:0] clamp_ext(input logic signed [WIDTH:0] v);
        if (v > c_max_ext) begin
            return c_max_ext;
        end else if (v < c_min_ext) begin
            return c_min_ext;
        end else begin
            return v;
        end
    endfunction

    logic signed [WIDTH:0]   w_acc_c;
    logic signed [WIDTH:0]   w_arg_c;
    logic signed [WIDTH:0]   w_sum;
    logic                    w_sat_pos;
    logic                    w_sat_neg;
    logic        [WIDTH-1:0] w_res;

    always_comb begin
        w_acc_c   = clamp_ext({acc[WIDTH-1], acc});
        w_arg_c   = clamp_ext({arg1[WIDTH-1], arg1});
        w_sum     = w_acc_c + w_arg_c;
        w_sat_pos = (w_sum > c_max_ext);
        w_sat_neg = (w_sum < c_min_ext);
        if (w_sat_pos) begin
            w_res = c_max_out;
        end else if (w_sat_neg) begin
            w_res = c_min_out;
        end else begin
            w_res = w_sum[WIDTH-1:0];
        end
    end

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_res;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

`ifdef ADD_STATUS_EN
    logic r_sat_pos;
    logic r_sat_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_pos <= 1'b0;
            r_sat_neg <= 1'b0;
        end else if (in_valid) begin
            r_sat_pos <= w_sat_pos;
            r_sat_neg <= w_sat_neg;
        end
    end

    assign sat_pos = r_sat_pos;
    assign sat_neg = r_sat_neg;
`else
    // Saturation detects still steer the result mux; only the flag outputs are dropped
    assign sat_pos = 1'b0;
    assign sat_neg = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_add.sv
// ============================================================================
// Module      : tb_alu_add
// Description : Self-checking bench for alu_add: directed cases plus randomized
//               traffic against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_add;

    localparam int WIDTH   = 11;
    localparam int MAX_VAL = 999;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             sat_pos;
    logic             sat_neg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int exp_out   = 0;
    int exp_valid = 0;
    int exp_sp    = 0;
    int exp_sn    = 0;

    alu_add #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .acc       (acc),
        .arg1      (arg1),
        .out       (out),
        .out_valid (out_valid),
        .sat_pos   (sat_pos),
        .sat_neg   (sat_neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lim(input int v);
        if (v > MAX_VAL)  return MAX_VAL;
        if (v < -MAX_VAL) return -MAX_VAL;
        return v;
    endfunction

    // One clock: drive, advance the model, check all outputs just after the edge
    task automatic step(input string tag, input bit r, input bit v, input int a, input int b);
        int s;
        rst      = r;
        in_valid = v;
        acc      = WIDTH'(a);
        arg1     = WIDTH'(b);
        @(posedge clk);
        if (r) begin
            exp_out = 0; exp_valid = 0; exp_sp = 0; exp_sn = 0;
        end else if (v) begin
            s         = lim(int'($signed(acc))) + lim(int'($signed(arg1)));
            exp_out   = lim(s);
            exp_valid = 1;
`ifdef ADD_STATUS_EN
            exp_sp    = (s > MAX_VAL)  ? 1 : 0;
            exp_sn    = (s < -MAX_VAL) ? 1 : 0;
`endif
        end else begin
            exp_valid = 0;
        end
        #1;
        chk({tag, ".out"},       int'($signed(out)), exp_out);
        chk({tag, ".out_valid"}, int'(out_valid),    exp_valid);
        chk({tag, ".sat_pos"},   int'(sat_pos),      exp_sp);
        chk({tag, ".sat_neg"},   int'(sat_neg),      exp_sn);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; acc = '0; arg1 = '0;

        step("rst0", 1, 0, 0, 0);
        step("rst1", 1, 1, 500, 500);  // reset wins over in_valid

        step("neg_sum",  0, 1, -51, -51);
        chk("neg_sum.const", int'($signed(out)), -102);
        step("pos_sum",  0, 1, 52, 53);
        chk("pos_sum.const", int'($signed(out)), 105);
        step("mix_pos",  0, 1, -25, 27);
        chk("mix_pos.const", int'($signed(out)), 2);
        step("mix_neg",  0, 1, -27, 25);
        chk("mix_neg.const", int'($signed(out)), -2);
        step("sat_neg",  0, 1, -951, -902);
        chk("sat_neg.const", int'($signed(out)), -999);
        step("sat_pos",  0, 1, 900, 900);
        chk("sat_pos.const", int'($signed(out)), 999);
        step("edge_max", 0, 1, 999, 0);
        chk("edge_max.const", int'($signed(out)), 999);
        step("edge_min", 0, 1, -999, 0);
        step("edge_sat", 0, 1, 500, 500);
        step("in_clamp", 0, 1, 1023, -1024);
        chk("in_clamp.const", int'($signed(out)), 0);
        step("zero",     0, 1, 7, -7);
        step("hold0",    0, 0, 300, 300);
        step("hold1",    0, 0, -900, -900);
        step("b2b0",     0, 1, 100, 200);
        step("b2b1",     0, 1, -400, 100);
        step("b2b2",     0, 1, 999, 999);
        step("midrst",   1, 1, 10, 10);
        step("after",    0, 1, -1000, -1000);

        for (int i = 0; i < 300; i++) begin
            bit r, v;
            int a, b;
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = int'($urandom_range(0, 2047)) - 1024;
            b = int'($urandom_range(0, 2047)) - 1024;
            step("rand", r, v, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
